// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C target controller (operation and FSM state encodings).
package i2c_pkg;
  typedef enum logic {WRITE = 1'b0, READ = 1'b1} i2c_op_t;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} i2c_tgt_state_t;
endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: synchronous FIFO with full/empty flags; push is dropped when full, pop when empty.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, do_push};
      rp <= rp + {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: oversampling I2C target with address match, write streaming and FIFO-fed reads.
// Define I2C_CLK_STRETCH_EN to stretch SCL on an empty read FIFO or a not-ready write host.
module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
  parameter int                        RD_FIFO_DEPTH  = 16,
  parameter int                        SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  output logic                      scl_oe,
  output logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  output logic                      busy,
  output i2c_op_t                   op,
  output logic                      start_det,
  output logic                      stop_det,
  output logic                      rd_underflow
);
  localparam int AW = I2C_ADDR_WIDTH;
  localparam int DW = I2C_DATA_WIDTH;
  localparam int SW = AW > DW - 1 ? AW : DW - 1;
  localparam int CW = $clog2((AW > DW ? AW : DW) + 1);
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_q, sda_q, scl_rise, scl_fall, start, stop;
  i2c_tgt_state_t state_q, state_d;
  i2c_op_t op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [DW-2:0] tx_q, tx_d;
  logic [DW-1:0] wr_data_q, wr_data_d, fifo_dout;
  logic sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d, drv_q, drv_d, busy_q, busy_d;
  logic wr_ok_q, wr_ok_d, wr_valid_q, wr_valid_d, udf_q, udf_d, start_q, stop_q;
  logic ld, pop, fifo_full, fifo_empty;
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start = scl_s & scl_q & sda_q & ~sda_s;
  assign stop = scl_s & scl_q & ~sda_q & sda_s;
  i2c_sync_fifo #(.WIDTH(DW), .DEPTH(RD_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(rd_valid), .pop(pop), .din(rd_data),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      state_q <= IDLE;
      op_q <= WRITE;
      cnt_q <= '0;
      sh_q <= '0;
      tx_q <= '0;
      wr_data_q <= '0;
      sda_oe_q <= 1'b0;
      scl_oe_q <= 1'b0;
      drv_q <= 1'b0;
      busy_q <= 1'b0;
      wr_ok_q <= 1'b0;
      wr_valid_q <= 1'b0;
      udf_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q <= scl_s;
      sda_q <= sda_s;
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      wr_data_q <= wr_data_d;
      sda_oe_q <= sda_oe_d;
      scl_oe_q <= scl_oe_d;
      drv_q <= drv_d;
      busy_q <= busy_d;
      wr_ok_q <= wr_ok_d;
      wr_valid_q <= wr_valid_d;
      udf_q <= udf_d;
      start_q <= start;
      stop_q <= stop;
    end
  // drv_q marks the second half of an ACK slot (or a received controller ACK in RD_ACK)
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    tx_d = tx_q;
    wr_data_d = wr_data_q;
    sda_oe_d = sda_oe_q;
    scl_oe_d = scl_oe_q;
    drv_d = drv_q;
    busy_d = busy_q;
    wr_ok_d = wr_ok_q;
    wr_valid_d = 1'b0;
    udf_d = udf_q;
    ld = 1'b0;
    pop = 1'b0;
    if (start) begin
      state_d = ADDR;
      cnt_d = '0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      udf_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      busy_d = 1'b0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
    end else if (scl_oe_q) begin
      if (state_q == RD_BYTE) begin
        ld = ~fifo_empty;
        scl_oe_d = fifo_empty;
      end else if (wr_ready) begin
        sda_oe_d = 1'b1;
        drv_d = 1'b1;
        scl_oe_d = 1'b0;
      end
    end else if (scl_rise) begin
      if (state_q == ADDR || state_q == WR_BYTE) begin
        sh_d = {sh_q[SW-2:0], sda_s};
        cnt_d = cnt_q + 1'b1;
      end
      if (state_q == ADDR && cnt_q == CW'(AW)) begin
        state_d = sh_q[AW-1:0] == TARGET_ADDR ? ADDR_ACK : IDLE;
        busy_d = sh_q[AW-1:0] == TARGET_ADDR;
        op_d = i2c_op_t'(sda_s);
        drv_d = 1'b0;
      end else if (state_q == WR_BYTE && cnt_q == CW'(DW - 1)) begin
        wr_data_d = {sh_q[DW-2:0], sda_s};
        wr_valid_d = 1'b1;
        wr_ok_d = wr_ready;
        state_d = WR_ACK;
        drv_d = 1'b0;
      end else if (state_q == RD_ACK) begin
        drv_d = ~sda_s;
        state_d = sda_s ? IDLE : RD_ACK;
      end
    end else if (scl_fall) begin
      if ((state_q == ADDR_ACK || state_q == WR_ACK) && !drv_q) begin
`ifdef I2C_CLK_STRETCH_EN
        scl_oe_d = state_q == WR_ACK && !wr_ok_q;
        sda_oe_d = ~scl_oe_d;
        drv_d = ~scl_oe_d;
`else
        sda_oe_d = state_q == ADDR_ACK || wr_ok_q;
        drv_d = 1'b1;
`endif
      end else if (state_q == ADDR_ACK || state_q == WR_ACK) begin
        drv_d = 1'b0;
        sda_oe_d = 1'b0;
        state_d = WR_BYTE;
        cnt_d = '0;
        ld = state_q == ADDR_ACK && op_q == READ;
      end else if (state_q == RD_BYTE) begin
        sda_oe_d = cnt_q < CW'(DW) ? ~tx_q[DW-2] : 1'b0;
        tx_d = tx_q << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q < CW'(DW) ? RD_BYTE : RD_ACK;
        drv_d = 1'b0;
      end else if (state_q == RD_ACK && drv_q) begin
        ld = 1'b1;
      end
    end
    // An empty FIFO yields an all-ones byte, i.e. SDA simply stays released
    if (ld) begin
      state_d = RD_BYTE;
      cnt_d = CW'(1);
      pop = ~fifo_empty;
      udf_d = udf_q | fifo_empty;
      sda_oe_d = ~(fifo_empty | fifo_dout[DW-1]);
      tx_d = fifo_empty ? '1 : fifo_dout[DW-2:0];
`ifdef I2C_CLK_STRETCH_EN
      if (fifo_empty) begin
        scl_oe_d = 1'b1;
        udf_d = udf_q;
        sda_oe_d = 1'b0;
      end
`endif
    end
  end
  assign sda_oe = sda_oe_q;
`ifdef I2C_CLK_STRETCH_EN
  assign scl_oe = scl_oe_q;
`else
  assign scl_oe = 1'b0;
`endif
  assign wr_data = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign rd_ready = ~fifo_full;
  assign busy = busy_q;
  assign op = op_q;
  assign start_det = start_q;
  assign stop_det = stop_q;
  assign rd_underflow = udf_q;
endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb_i2c_target_ctrl: bit-banged I2C controller with randomized transfers checked against a transaction-level model.
module tb_i2c_target_ctrl;
  localparam logic [6:0] TGT = 7'h22;
  localparam int Q = 8;
  logic clk = 1'b0;
  logic rst_n, scl_m, sda_m, wr_ready, rd_valid;
  logic [7:0] rd_data;
  logic sda_oe, scl_oe, wr_valid, rd_ready, busy, op, start_det, stop_det, rd_underflow;
  logic [7:0] wr_data;
  logic scl, sda;
  int n_vec = 0, n_err = 0, n_start = 0, n_stop = 0;
  logic [7:0] got_wr[$], exp_wr[$], mq[$];
  logic [7:0] wbuf[4];
  assign scl = scl_m & ~scl_oe;
  assign sda = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target_ctrl dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda), .sda_oe(sda_oe), .scl_oe(scl_oe),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .op(op), .start_det(start_det),
    .stop_det(stop_det), .rd_underflow(rd_underflow)
  );
  always @(negedge clk) begin
    if (wr_valid) got_wr.push_back(wr_data);
    if (start_det) n_start++;
    if (stop_det) n_stop++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wt();
    repeat (Q) @(negedge clk);
  endtask
  task automatic scl_up();
    scl_m = 1'b1;
    for (int i = 0; i < 4000 && scl !== 1'b1; i++) @(negedge clk);
    if (scl !== 1'b1) chk("scl_release", 32'(scl), 32'd1);
  endtask
  task automatic xbit(input logic b, output logic r);
    sda_m = b;
    wt();
    scl_up();
    wt();
    r = sda;
    scl_m = 1'b0;
    wt();
  endtask
  task automatic xstart();
    int s0;
    s0 = n_start;
    sda_m = 1'b1;
    wt();
    scl_up();
    wt();
    sda_m = 1'b0;
    wt();
    scl_m = 1'b0;
    wt();
    chk("start_det", 32'(n_start), 32'(s0 + 1));
    chk("udf_clear", 32'(rd_underflow), 32'd0);
  endtask
  task automatic xstop();
    int p0;
    p0 = n_stop;
    sda_m = 1'b0;
    wt();
    scl_up();
    wt();
    sda_m = 1'b1;
    wt();
    chk("stop_det", 32'(n_stop), 32'(p0 + 1));
    chk("busy_end", 32'(busy), 32'd0);
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xbit(d[i], r);
    xbit(1'b1, r);
    ack = ~r;
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xbit(1'b1, r);
      d[i] = r;
    end
    xbit(nack, r);
  endtask
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    chk("rd_ready", 32'(rd_ready), 32'(mq.size() < 16));
    rd_data = b;
    rd_valid = 1'b1;
    if (mq.size() < 16) mq.push_back(b);
    @(negedge clk);
    rd_valid = 1'b0;
  endtask
  task automatic wr_xfer(input logic [6:0] a, input int n, input logic rdy, input logic do_stop);
    logic ack, m;
    got_wr.delete();
    exp_wr.delete();
    wr_ready = rdy;
    m = a == TGT;
    xstart();
    wr_byte({a, 1'b0}, ack);
    chk("addr_ack", 32'(ack), 32'(m));
    chk("busy", 32'(busy), 32'(m));
    if (m) chk("op_write", 32'(op), 32'd0);
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], ack);
      chk("wr_ack", 32'(ack), 32'(m & rdy));
      if (m) exp_wr.push_back(wbuf[i]);
    end
    if (do_stop) xstop();
    chk("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) chk("wr_data", 32'(got_wr[i]), 32'(exp_wr[i]));
  endtask
  task automatic rd_xfer(input int n);
    logic ack, udf;
    logic [7:0] d, e;
    udf = 1'b0;
    xstart();
    wr_byte({TGT, 1'b1}, ack);
    chk("rd_addr_ack", 32'(ack), 32'd1);
    chk("op_read", 32'(op), 32'd1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      if (mq.size() > 0) e = mq.pop_front();
      else begin
        e = 8'hFF;
        udf = 1'b1;
      end
      chk("rd_data", 32'(d), 32'(e));
    end
    xstop();
    chk("rd_underflow", 32'(rd_underflow), 32'(udf));
    chk("rd_ready_end", 32'(rd_ready), 32'(mq.size() < 16));
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic r;
    int k, n;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wr_ready = 1'b1;
    rd_valid = 1'b0;
    rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_ready", 32'(rd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_start_det", 32'(start_det), 32'd0);
    chk("rst_stop_det", 32'(stop_det), 32'd0);
    chk("rst_underflow", 32'(rd_underflow), 32'd0);
    rst_n = 1'b1;
    wt();
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    wr_xfer(TGT, 2, 1'b1, 1'b1);
    wbuf[0] = 8'h5E;
    wr_xfer(7'h23, 1, 1'b1, 1'b1);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    rd_xfer(3);
    chk("fifo_drained", 32'(mq.size()), 32'd0);
`ifndef I2C_CLK_STRETCH_EN
    rd_xfer(2);
    wbuf[0] = 8'h77;
    wr_xfer(TGT, 1, 1'b0, 1'b0);
`else
    fork
      begin
        repeat (300) @(negedge clk);
        chk("scl_hold", 32'(scl_oe), 32'd1);
        push(8'h5A);
      end
      rd_xfer(1);
    join
    wbuf[0] = 8'h77;
    wr_xfer(TGT, 1, 1'b1, 1'b0);
`endif
    push(8'hC3);
    rd_xfer(1);
    push(8'h99);
    push(8'h98);
    xstart();
    for (int i = 6; i >= 0; i--) xbit(TGT[i], r);
    xbit(1'b0, r);
    chk("ack_drive", 32'(sda_oe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rd_ready", 32'(rd_ready), 32'd1);
    mq.delete();
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wt();
`ifdef I2C_CLK_STRETCH_EN
    push(8'h4B);
`endif
    rd_xfer(1);
    for (int i = 0; i < 18; i++) push(8'($urandom));
    rd_xfer(16);
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
`ifdef I2C_CLK_STRETCH_EN
        wr_xfer($urandom_range(0, 3) == 0 ? 7'($urandom) : TGT, n, 1'b1, 1'b1);
`else
        wr_xfer($urandom_range(0, 3) == 0 ? 7'($urandom) : TGT, n, 1'($urandom), 1'b1);
`endif
      end else begin
`ifdef I2C_CLK_STRETCH_EN
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) push(8'($urandom));
        n = $urandom_range(1, mq.size());
`else
        k = $urandom_range(0, 4);
        for (int i = 0; i < k; i++) push(8'($urandom));
        n = $urandom_range(1, 4);
`endif
        rd_xfer(n);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_target_ctrl.md
Name: i2c_target_ctrl

Overview:
- Synthesizable, parametrised I2C target (slave) controller running on the system clock.
- Oversamples the open-drain SCL/SDA pins and detects START, repeated START and STOP.
- Matches a programmable address, ACKs, and streams write bytes out on a valid pulse. Read bytes come from an internal FIFO that the host side fills.
- Sits behind the I2C bus pins of the multi-bus controller testbench top as the RTL counterpart of the behavioural I2C target.

Parameters:
- I2C_ADDR_WIDTH, 7, target address width.
- I2C_DATA_WIDTH, 8, bits per data byte.
- TARGET_ADDR, 7'h22, address this target responds to.
- RD_FIFO_DEPTH, 16, read-data FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i; at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low.
- scl_oe  out  1  1 = pull SCL low (stretch).
- wr_data  out  I2C_DATA_WIDTH  received write byte.
- wr_valid  out  1  one-cycle pulse, wr_data valid.
- wr_ready  in  1  host can accept a byte; 0 → NACK.
- rd_data  in  I2C_DATA_WIDTH  read byte pushed into the FIFO.
- rd_valid  in  1  push request.
- rd_ready  out  1  FIFO not full.
- busy  out  1  addressed transaction in progress.
- op  out  1  i2c_op_t of the current or last transaction.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- rd_underflow  out  1  sticky; cleared by the next START.

Behaviour:
- Reset values: sda_oe=0, scl_oe=0, wr_valid=0, wr_data=0, rd_ready=1, busy=0, op=WRITE, start_det=0, stop_det=0, rd_underflow=0. FIFO empty, state IDLE.
- Reset mid-transfer releases both lines within the same cycle (asynchronous).
- Edge detection: scl/sda pass through SYNC_STAGES flops; edges are taken on the synchronized values.
  - START: sda falls while scl high.
  - STOP: sda rises while scl high.
- START or STOP in any state aborts the current byte, releases sda_oe, and pulses the matching _det output.
  - START → ADDR.
  - STOP → IDLE, busy=0.
- Sampling and driving: sample SDA on scl rising edge; update sda_oe only on scl falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
  - ADDR: shift I2C_ADDR_WIDTH bits MSB-first, then the R/W bit.
    - Mismatch → IDLE; sda_oe stays 0; wait for the next START.
    - Match → ADDR_ACK; op latched; busy=1.
  - ADDR_ACK: sda_oe=1 for one SCL period (falling to falling edge).
    - Then WR_BYTE if op=WRITE, RD_BYTE if READ.
  - WR_BYTE: shift I2C_DATA_WIDTH bits.
    - On the last rising edge: wr_data updated, wr_valid=1 for one clk. This is 3 clk after the synchronized edge at most.
    - Go to WR_ACK.
  - WR_ACK: ACK (sda_oe=1) if wr_ready was 1 when the byte completed, else NACK.
    - Then WR_BYTE.
  - RD_BYTE: on entry pop the FIFO head.
    - Drive sda_oe = ~bit MSB-first, one bit per SCL falling edge.
    - Release SDA after the last bit; go to RD_ACK.
  - RD_ACK: sample the controller ACK on scl rise.
    - ACK (0) → RD_BYTE.
    - NACK (1) → IDLE-wait: stay released until STOP or START.
- FIFO rules:
  - Push when rd_valid & rd_ready.
  - Pop and push in the same cycle are both honoured when non-empty.
  - rd_ready = ~full; pointers wrap modulo RD_FIFO_DEPTH.
  - Pop while empty: shift 0xFF (SDA released) and set rd_underflow.
- op encoding: WRITE=0, READ=1.

Optional Feature:
- I2C_CLK_STRETCH_EN.
- Defined: entering RD_BYTE with the FIFO empty, or WR_ACK with wr_ready=0, holds scl_oe=1 from the SCL falling edge until data arrives or wr_ready rises. Then release and continue: the byte is ACKed or sent normally, and rd_underflow is never set.
- Undefined: scl_oe tied 0; the empty or not-ready behaviour is as described under Behaviour.

Decomposition:
- i2c_pkg: i2c_op_t (WRITE, READ) and i2c_tgt_state_t (FSM enum).
- Sub-module i2c_sync_fifo (parametrised width/depth, full/empty, simultaneous push/pop) holds the read data.
- Synchronizer and edge detect stay inline.

Test Plan:
- Write to 0x22, bytes 0xA5 then 0x3C, wr_ready=1 → ACK on address and both bytes; wr_valid pulses with 0xA5 then 0x3C; stop_det pulse; busy 1→0.
- Write to 0x23 → no ACK (SDA high in the ACK slot); wr_valid never asserts; busy stays 0.
- Preload FIFO with 0x11, 0x22, 0x33; read 3 bytes, NACK on the last → bus carries 0x11, 0x22, 0x33; FIFO empty; rd_underflow=0.
- Read 2 bytes with an empty FIFO, macro undefined → 0xFF, 0xFF on the bus; rd_underflow=1; cleared at the next START. With the macro defined: SCL is held low until the host pushes 0x5A, then 0x5A is transferred.
- Write 0x77 with wr_ready=0 → NACK on the data byte; then repeated START and read to 0x22 → start_det pulse, op=READ, address ACKed.
- Assert rst_n=0 mid-byte while sda_oe=1 → sda_oe=0 immediately; FIFO emptied; next transfer works normally.
